cache_line_filler: RTL and testbench

//  Responder side of the sequencer's cache-miss handshake. On a miss it reads one 32-byte line

---
 rtl/cache_fill_pkg.sv | 20 ++
 rtl/fill_offset_pipe.sv | 43 ++++
 rtl/cache_line_filler.sv | 186 ++++++++++++++++++
 tb/tb_cache_line_filler.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_pkg.sv
// Shared definitions for the instruction-cache fill path: FSM state encoding
// and the default geometry used by cache, program_sequencer and the filler.
package cache_fill_pkg;

  localparam int DEFAULT_ADDR_W      = 8;
  localparam int DEFAULT_DATA_W      = 8;
  localparam int DEFAULT_OFFSET_W    = 5;
  localparam int DEFAULT_ROM_LATENCY = 1;

  localparam int LINE_BYTES = 2 ** DEFAULT_OFFSET_W;
  localparam int TAG_W      = DEFAULT_ADDR_W - DEFAULT_OFFSET_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_e;

endpackage : cache_fill_pkg

// File: rtl/fill_offset_pipe.sv
// fill_offset_pipe: DEPTH-stage delay line carrying the issue-valid flag and
// line offset of each ROM request, so they emerge in the same cycle as the
// matching rom_data.
module fill_offset_pipe
  import cache_fill_pkg::*;
#(
  parameter int OFFSET_W = DEFAULT_OFFSET_W,
  parameter int DEPTH    = DEFAULT_ROM_LATENCY
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [OFFSET_W-1:0] in_off,
  output logic                out_valid,
  output logic [OFFSET_W-1:0] out_off
);

  logic [DEPTH-1:0]    vld_q;
  logic [OFFSET_W-1:0] off_q [DEPTH];

  // Shift valid and offset one stage per clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      // NOTE: this small array is reset (unlike a RAM) so an aborted fill can
      // never leave a stale offset paired with a valid in flight.
      for (int i = 0; i < DEPTH; i++) begin
        off_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid;
      off_q[0] <= in_off;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        off_q[i] <= off_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_off   = off_q[DEPTH-1];

endmodule : fill_offset_pipe

// File: rtl/cache_line_filler.sv
// cache_line_filler: answers the sequencer's miss handshake by streaming one
// full line from program memory into the single-line instruction cache, then
// pulsing fill_done. Tracks residency (line_valid/line_tag) and flushes.
// Optional feature macro: CRITICAL_WORD_FIRST_EN (start the fill at the
// missed byte and wrap; crit_ready marks the first write). Default build
// fills from offset 0 and ties crit_ready low.
module cache_line_filler
  import cache_fill_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int OFFSET_W    = DEFAULT_OFFSET_W,
  parameter int ROM_LATENCY = DEFAULT_ROM_LATENCY
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       miss_req,
  input  logic [ADDR_W-1:0]          miss_addr,
  input  logic                       invalidate,
  output logic [ADDR_W-1:0]          rom_address,
  input  logic [DATA_W-1:0]          rom_data,
  output logic                       cache_wren,
  output logic [OFFSET_W-1:0]        cache_wroffset,
  output logic [DATA_W-1:0]          cache_data,
  output logic                       fill_busy,
  output logic                       fill_done,
  output logic                       line_valid,
  output logic [ADDR_W-OFFSET_W-1:0] line_tag,
  output logic                       crit_ready
);

  localparam int TAG_BITS = ADDR_W - OFFSET_W;
  localparam int LINE_LEN = 2 ** OFFSET_W;

  localparam logic [OFFSET_W:0]   ISSUE_ALL = (OFFSET_W+1)'(LINE_LEN);
  localparam logic [OFFSET_W:0]   CNT_ONE   = (OFFSET_W+1)'(1);
  localparam logic [OFFSET_W-1:0] OFF_ONE   = OFFSET_W'(1);

  fill_state_e         state;
  logic                issue_valid;   // rom_address carries a live request
  logic [OFFSET_W:0]   iss_cnt;       // requests issued so far this fill
  logic [OFFSET_W-1:0] wr_cnt;        // cache writes completed this fill
  logic                inv_sticky;    // flush seen while a fill was in flight

  logic [TAG_BITS-1:0] miss_tag;
  logic [OFFSET_W-1:0] start_off;
  logic                pipe_valid;
  logic [OFFSET_W-1:0] pipe_off;

  assign miss_tag = miss_addr[ADDR_W-1:OFFSET_W];

`ifdef CRITICAL_WORD_FIRST_EN
  logic [OFFSET_W-1:0] crit_off;      // offset of the byte that missed
  assign start_off = miss_addr[OFFSET_W-1:0];
`else
  logic unused_low_addr;
  assign start_off       = '0;
  assign unused_low_addr = ^miss_addr[OFFSET_W-1:0];
`endif

  // Control FSM: accept misses, issue one ROM address per cycle, count the
  // returning writes, and publish residency at DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      rom_address <= '0;
      issue_valid <= 1'b0;
      iss_cnt     <= '0;
      wr_cnt      <= '0;
      inv_sticky  <= 1'b0;
      fill_busy   <= 1'b0;
      fill_done   <= 1'b0;
      line_valid  <= 1'b0;
      line_tag    <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
      crit_off    <= '0;
`endif
    end else begin
      // NOTE: state and outputs use non-blocking assignments so every branch
      // below reads the values from before this edge, like real flip-flops.
      fill_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (miss_req && (invalidate || !line_valid || line_tag != miss_tag)) begin
            // Miss (a same-cycle flush turns a hit into a miss as well).
            state       <= ST_ISSUE;
            line_tag    <= miss_tag;
            line_valid  <= 1'b0;
            inv_sticky  <= 1'b0;
            fill_busy   <= 1'b1;
            rom_address <= {miss_tag, start_off};
            issue_valid <= 1'b1;
            iss_cnt     <= CNT_ONE;
            wr_cnt      <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            crit_off    <= start_off;
`endif
          end else if (miss_req) begin
            // Already resident: release the sequencer without touching ROM.
            state     <= ST_DONE;
            fill_done <= 1'b1;
          end else if (invalidate) begin
            line_valid <= 1'b0;
          end
        end

        ST_ISSUE, ST_FILL: begin
          if (state == ST_ISSUE) begin
            state <= ST_FILL;
          end
          if (invalidate) begin
            inv_sticky <= 1'b1;
          end
          // Address stream: offset wraps inside the line, never crossing it.
          if (iss_cnt != ISSUE_ALL) begin
            rom_address[OFFSET_W-1:0] <= rom_address[OFFSET_W-1:0] + OFF_ONE;
            iss_cnt                   <= iss_cnt + CNT_ONE;
            issue_valid               <= 1'b1;
          end else begin
            issue_valid <= 1'b0;
          end
          // Write stream: the last write hands over to DONE.
          if (cache_wren) begin
            wr_cnt <= wr_cnt + OFF_ONE;
            if (wr_cnt == '1) begin
              state      <= ST_DONE;
              fill_done  <= 1'b1;
              fill_busy  <= 1'b0;
              line_valid <= !(inv_sticky || invalidate);
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          if (invalidate) begin
            line_valid <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  fill_offset_pipe #(
    .OFFSET_W (OFFSET_W),
    .DEPTH    (ROM_LATENCY)
  ) u_offset_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (issue_valid),
    .in_off    (rom_address[OFFSET_W-1:0]),
    .out_valid (pipe_valid),
    .out_off   (pipe_off)
  );

  // Cache write port: register returned data with its aligned offset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cache_wren     <= 1'b0;
      cache_wroffset <= '0;
      cache_data     <= '0;
    end else begin
      cache_wren <= pipe_valid;
      if (pipe_valid) begin
        cache_wroffset <= pipe_off;
        cache_data     <= rom_data;
      end
    end
  end

`ifdef CRITICAL_WORD_FIRST_EN
  // Flag the write of the byte the sequencer is waiting on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crit_ready <= 1'b0;
    end else begin
      crit_ready <= pipe_valid && (pipe_off == crit_off);
    end
  end
`else
  assign crit_ready = 1'b0;
`endif

endmodule : cache_line_filler

// File: tb/tb_cache_line_filler.sv
// Directed bench for cache_line_filler: one instance at ROM latency 1 and one
// at ROM latency 3, each with a behavioural ROM; `sel` picks which instance
// the stimulus drives and observes.
module tb_cache_line_filler;
  import cache_fill_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic       sel = 1'b0;
  logic       miss_req = 1'b0;
  logic       invalidate = 1'b0;
  logic [7:0] miss_addr = '0;

  logic       miss_req1, miss_req3, inval1, inval3;
  logic [7:0] rom_address1, rom_address3, rom_data1, rom_data3;
  logic [7:0] cache_data1, cache_data3;
  logic [4:0] cache_wroffset1, cache_wroffset3;
  logic [2:0] line_tag1, line_tag3;
  logic       cache_wren1, cache_wren3, fill_busy1, fill_busy3;
  logic       fill_done1, fill_done3, line_valid1, line_valid3;
  logic       crit_ready1, crit_ready3;

  assign miss_req1 = miss_req & ~sel;
  assign miss_req3 = miss_req & sel;
  assign inval1    = invalidate & ~sel;
  assign inval3    = invalidate & sel;

  function automatic logic [7:0] rom_fn(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'h3C;
  endfunction

  // ROM models: data appears 1 and 3 cycles after the address.
  logic [7:0] rom3_q [3];
  always @(posedge clk) begin
    rom_data1 <= rom_fn(rom_address1);
    rom3_q[0] <= rom_fn(rom_address3);
    rom3_q[1] <= rom3_q[0];
    rom3_q[2] <= rom3_q[1];
  end
  assign rom_data3 = rom3_q[2];

  cache_line_filler #(.ROM_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .miss_req(miss_req1), .miss_addr(miss_addr),
    .invalidate(inval1), .rom_address(rom_address1), .rom_data(rom_data1),
    .cache_wren(cache_wren1), .cache_wroffset(cache_wroffset1),
    .cache_data(cache_data1), .fill_busy(fill_busy1), .fill_done(fill_done1),
    .line_valid(line_valid1), .line_tag(line_tag1), .crit_ready(crit_ready1)
  );

  cache_line_filler #(.ROM_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .miss_req(miss_req3), .miss_addr(miss_addr),
    .invalidate(inval3), .rom_address(rom_address3), .rom_data(rom_data3),
    .cache_wren(cache_wren3), .cache_wroffset(cache_wroffset3),
    .cache_data(cache_data3), .fill_busy(fill_busy3), .fill_done(fill_done3),
    .line_valid(line_valid3), .line_tag(line_tag3), .crit_ready(crit_ready3)
  );

  logic       o_wren, o_busy, o_done, o_lv, o_crit;
  logic [4:0] o_off;
  logic [7:0] o_data, o_rom_addr;
  logic [2:0] o_tag;
  logic [1:0] o_state;
  assign o_wren     = sel ? cache_wren3     : cache_wren1;
  assign o_off      = sel ? cache_wroffset3 : cache_wroffset1;
  assign o_data     = sel ? cache_data3     : cache_data1;
  assign o_busy     = sel ? fill_busy3      : fill_busy1;
  assign o_done     = sel ? fill_done3      : fill_done1;
  assign o_lv       = sel ? line_valid3     : line_valid1;
  assign o_tag      = sel ? line_tag3       : line_tag1;
  assign o_crit     = sel ? crit_ready3     : crit_ready1;
  assign o_rom_addr = sel ? rom_address3    : rom_address1;
  assign o_state    = sel ? u_dut3.state    : u_dut1.state;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string who);
    chk({who, "_wren"},  32'(o_wren),     0);
    chk({who, "_busy"},  32'(o_busy),     0);
    chk({who, "_done"},  32'(o_done),     0);
    chk({who, "_lv"},    32'(o_lv),       0);
    chk({who, "_tag"},   32'(o_tag),      0);
    chk({who, "_crit"},  32'(o_crit),     0);
    chk({who, "_raddr"}, 32'(o_rom_addr), 0);
    chk({who, "_state"}, 32'(o_state),    32'(ST_IDLE));
  endtask

  // Raise miss_req for addr, follow the handshake to fill_done, check it.
  task automatic do_fill(input string nm, input logic [7:0] addr, input int lat,
                         input bit inv_at5, input bit inv_at_accept,
                         input bit is_hit, input bit exp_valid_end);
    int         nwr, done_cyc, first_wr, ncrit, crit_first, oob, lv_bad, busy_bad;
    logic [4:0] start, exp_off;
    logic [2:0] tag;
    logic [7:0] raddr0;
    tag = addr[7:5];
`ifdef CRITICAL_WORD_FIRST_EN
    start = addr[4:0];
`else
    start = 5'd0;
`endif
    nwr = 0; done_cyc = -1; first_wr = -1; ncrit = 0; crit_first = 0;
    oob = 0; lv_bad = 0; busy_bad = 0;
    raddr0     = o_rom_addr;
    miss_addr  = addr;
    miss_req   = 1'b1;
    invalidate = inv_at_accept;
    for (int c = 0; c < 80 && done_cyc < 0; c++) begin
      step();
      invalidate = 1'b0;
      if (o_wren) begin
        exp_off = start + 5'(nwr);
        chk({nm, "_wr_off"},  32'(o_off),  32'(exp_off));
        chk({nm, "_wr_data"}, 32'(o_data), 32'(rom_fn({tag, exp_off})));
        if (nwr == 0) begin
          first_wr   = c;
          crit_first = int'(o_crit);
        end
        nwr++;
        if (inv_at5 && nwr == 6) invalidate = 1'b1;
      end
      if (o_crit) ncrit++;
      if (o_busy && o_rom_addr[7:5] != tag) oob++;
      if (!is_hit && !o_done && o_lv) lv_bad++;
      if (o_busy !== (!is_hit && !o_done)) busy_bad++;
      if (o_done) begin
        done_cyc = c;
        chk({nm, "_lv_at_done"}, 32'(o_lv), 32'(exp_valid_end));
        chk({nm, "_tag"},        32'(o_tag), 32'(tag));
        miss_req = 1'b0;
      end
    end
    chk({nm, "_done_cyc"}, 32'(done_cyc), is_hit ? 0 : 32'(32 + lat + 1));
    chk({nm, "_nwrites"},  32'(nwr),      is_hit ? 0 : 32);
    chk({nm, "_busy_seq"}, 32'(busy_bad), 0);
    if (is_hit) begin
      chk({nm, "_raddr_kept"}, 32'(o_rom_addr), 32'(raddr0));
    end else begin
      chk({nm, "_first_wr"}, 32'(first_wr), 32'(lat + 1));
      chk({nm, "_addr_in_line"}, 32'(oob), 0);
      chk({nm, "_lv_during"}, 32'(lv_bad), 0);
    end
`ifdef CRITICAL_WORD_FIRST_EN
    chk({nm, "_ncrit"}, 32'(ncrit), is_hit ? 0 : 1);
    if (!is_hit) chk({nm, "_crit_first"}, 32'(crit_first), 1);
`else
    chk({nm, "_ncrit"}, 32'(ncrit), 0);
`endif
    miss_req = 1'b0;
    step();
    chk({nm, "_done_pulse"}, 32'(o_done),  0);
    chk({nm, "_idle"},       32'(o_state), 32'(ST_IDLE));
  endtask

  initial begin
    int nwr;
    // Reset state of both instances.
    repeat (3) step();
    sel = 1'b0; #1; chk_reset_state("rst1");
    sel = 1'b1; #1; chk_reset_state("rst3");
    sel = 1'b0;
    reset = 1'b1;
    step();

    // Cold miss, hit on same line, flush in IDLE, refill.
    do_fill("cold47", 8'h47, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    do_fill("hit4a", 8'h4A, 1, 1'b0, 1'b0, 1'b1, 1'b1);
    invalidate = 1'b1;
    step();
    invalidate = 1'b0;
    chk("idle_inval_lv", 32'(o_lv), 0);
    do_fill("refill4a", 8'h4A, 1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Flush coinciding with a would-be hit: refilled, ends valid.
    do_fill("inv_acc", 8'h4A, 1, 1'b0, 1'b1, 1'b0, 1'b1);

    // Flush during the fill: all writes happen, line ends invalid.
    do_fill("inv_mid_bd", 8'hBD, 1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-fill after the tenth write.
    miss_addr = 8'h47;
    miss_req  = 1'b1;
    nwr = 0;
    for (int c = 0; c < 60 && nwr < 10; c++) begin
      step();
      if (o_wren) nwr++;
    end
    chk("rst_mid_reach10", 32'(nwr), 10);
    reset    = 1'b0;
    miss_req = 1'b0;
    step();
    chk_reset_state("rst_mid");
    reset = 1'b1;
    step();
    do_fill("after_rst", 8'h47, 1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Three-cycle ROM.
    sel = 1'b1;
    step();
    do_fill("lat3_00", 8'h00, 3, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_cache_line_filler
